muldiv_seq: RTL
===============

# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the single-cycle CPU. It decodes the 3-bit `mdu` command from `control` and either writes HI/LO in one cycle or runs a 32-step shift-add / shift-subtract engine. While the engine runs it holds the instruction by driving `pc_ena` low to `pcreg`. It replaces the ad-hoc HI/LO block and gives the stall handshake an explicit state machine.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`, input, 1: CPU clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mdu`, input, 3: command. 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- `rdata1`, input, 32: rs operand (dividend or multiplicand; source for mthi/mtlo).
- `rdata2`, input, 32: rt operand (divisor or multiplier).
- `hi`, output, 32: HI register.
- `lo`, output, 32: LO register.
- `pc_ena`, output, 1: 0 stalls PC and register/memory writeback; combinational from state and `mdu`.
- `busy`, output, 1: 1 in LOAD-to-DONE span excluding DONE; debug/visibility.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `mdu` ∈ {mult, multu, div, divu}:
  - Latch |rs| and |rt| (signed ops) or raw values (unsigned ops).
  - Latch the result-sign flags.
  - Clear the accumulator, set `count=0`, go to RUN.
  - Drive `pc_ena=0`.
- IDLE with mthi/mtlo: write `rdata1` to HI or LO at the clock edge, `pc_ena=1`, stay in IDLE.
- IDLE with none: `pc_ena=1`; HI and LO hold.
- RUN: one iteration per cycle, `count` increments.
  - Multiply: shift-add into a 64-bit {acc, multiplier} register.
  - Divide: restoring shift-subtract; the 64-bit {rem, quot} register shifts left each step.
  - After iteration 32 (`count==31` at the edge), go to DONE. `pc_ena=0` throughout.
- DONE:
  - HI/LO are written at the edge that leaves DONE.
  - Product: HI=upper 32 bits, LO=lower 32 bits. Negate the 64-bit product if the signs differ (mult).
  - Divide: LO=quotient, HI=remainder. Signed div negates the quotient if the signs differ; the remainder takes the sign of the dividend.
  - `pc_ena=1`; next state IDLE, so the next instruction is fetched.
- Divide by zero (rt==0, div or divu): still takes the full sequence. Result LO=32'hFFFF_FFFF, HI=`rdata1` as latched (raw signed value for div).
- Signed corner: div 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0 (wraps; no exception).
- `mdu` is ignored in RUN and DONE. The operands are already latched, so changes on `rdata1`/`rdata2` in those states have no effect.

## Timing
- Reset: state=IDLE, `hi=0`, `lo=0`, `count=0`, `busy=0`, `pc_ena=1` while `reset` is high.
- Reset asserted in RUN or DONE aborts at that edge: HI/LO are cleared, and no partial result is written.
- Latencies:
  - mthi/mtlo: 1 cycle; the new value is visible on `hi`/`lo` the cycle after.
  - Iterative mult/div: 34 cycles per instruction (1 IDLE/load + 32 RUN + 1 DONE). `pc_ena` is low for exactly the first 33 of them.
  - `hi`/`lo` keep their old values until the DONE edge. An mfhi immediately after the instruction reads the new value.
- The engine never re-triggers on the same instruction, because DONE always returns to IDLE together with a PC advance.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - mult/multu compute the 64-bit product combinationally in IDLE and write HI/LO at that edge. `pc_ena=1`, 1-cycle latency, no RUN.
  - div/divu are unchanged.
- Undefined: all four ops use the 34-cycle iterative path, and no `*` operator is synthesized.

## Test plan
- Reset, then `mdu`=101 with rs=0x1234_5678 → `hi`=0x1234_5678 next cycle, `lo`=0, `pc_ena` stays 1.
- multu rs=0xFFFF_FFFF, rt=0x2 → `pc_ena` low 33 cycles; after DONE `hi`=0x0000_0001, `lo`=0xFFFF_FFFE. With `MULDIV_FAST_MULT_EN`: same values after 1 cycle, `pc_ena` never low.
- mult rs=-7 (0xFFFF_FFF9), rt=3 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB.
- div rs=-7, rt=2 → `lo`=0xFFFF_FFFD (-3), `hi`=0xFFFF_FFFF (-1). divu rs=100, rt=7 → `lo`=14, `hi`=2.
- divu rs=0x55, rt=0 → after 34 cycles `lo`=0xFFFF_FFFF, `hi`=0x55.
- Start div, assert `reset` on RUN cycle 10 → next cycle state IDLE, `hi`=`lo`=0, `pc_ena`=1. A following mtlo 0xA → `lo`=0xA.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls the PC while the engine runs.
// Define MULDIV_FAST_MULT_EN for single-cycle combinational mult/multu.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mdu,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             pc_ena,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, rs_q, rs_d;
  logic [W2-1:0]    pr_q, pr_d;
  logic             div_q, div_d, neg_q, neg_d;
  logic             rneg_q, rneg_d, dz_q, dz_d;

  logic             is_mul, is_div, sgn, start;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH:0]   msum, dtry;
  logic [W2:0]      dsh;
  logic [W2-1:0]    mstep, dstep, prod;
  logic [WIDTH-1:0] quo, rem;

  assign is_mul = (mdu == OP_MULT) || (mdu == OP_MULTU);
  assign is_div = (mdu == OP_DIV) || (mdu == OP_DIVU);
  assign sgn    = (mdu == OP_MULT) || (mdu == OP_DIV);
`ifdef MULDIV_FAST_MULT_EN
  assign start  = is_div;
`else
  assign start  = is_mul || is_div;
`endif

  assign abs_rs = (sgn && rdata1[WIDTH-1]) ? -rdata1 : rdata1;
  assign abs_rt = (sgn && rdata2[WIDTH-1]) ? -rdata2 : rdata2;

  // Shift-add: {acc, multiplier} shifts right, acc gains a when LSB is set.
  assign msum  = {1'b0, pr_q[W2-1:WIDTH]} + {1'b0, a_q};
  assign mstep = pr_q[0] ? {msum, pr_q[WIDTH-1:1]}
                         : {1'b0, pr_q[W2-1:1]};

  // Restoring divide: {rem, quot} shifts left, subtract kept when non-negative.
  assign dsh   = {pr_q, 1'b0};
  assign dtry  = dsh[W2:WIDTH] - {1'b0, a_q};
  assign dstep = dtry[WIDTH] ? dsh[W2-1:0]
                             : {dtry[WIDTH-1:0], dsh[WIDTH-1:1], 1'b1};

  assign prod = neg_q ? -pr_q : pr_q;
  assign quo  = pr_q[WIDTH-1:0];
  assign rem  = pr_q[W2-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  logic [W2-1:0] fprod, fres;
  assign fprod = {{WIDTH{1'b0}}, abs_rs} * {{WIDTH{1'b0}}, abs_rt};
  assign fres  = (sgn && (rdata1[WIDTH-1] ^ rdata2[WIDTH-1])) ? -fprod : fprod;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    rs_d    = rs_q;
    pr_d    = pr_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = abs_rt;
          pr_d    = {{WIDTH{1'b0}}, abs_rs};
          rs_d    = rdata1;
          div_d   = is_div;
          neg_d   = sgn && (rdata1[WIDTH-1] ^ rdata2[WIDTH-1]);
          rneg_d  = sgn && rdata1[WIDTH-1];
          dz_d    = is_div && (rdata2 == '0);
          count_d = '0;
          state_d = S_RUN;
`ifdef MULDIV_FAST_MULT_EN
        end else if (is_mul) begin
          {hi_d, lo_d} = fres;
`endif
        end else if (mdu == OP_MTHI) begin
          hi_d = rdata1;
        end else if (mdu == OP_MTLO) begin
          lo_d = rdata1;
        end
      end
      S_RUN: begin
        pr_d    = div_q ? dstep : mstep;
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!div_q) begin
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = rs_q;
        end else begin
          lo_d = neg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      rs_q    <= '0;
      pr_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      rs_q    <= rs_d;
      pr_q    <= pr_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy   = !reset && ((state_q == S_RUN) ||
                             ((state_q == S_IDLE) && start));
  assign pc_ena = !busy;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule
